icache_ctrl: RTL and testbench



---
 rtl/icache_pkg.sv | 36 +++
 rtl/icache_tag_array.sv | 39 +++
 rtl/icache_ctrl.sv | 150 +++++++++++++++
 tb/tb_icache_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types, geometry and address-field helpers for the instruction cache controller.
// Pure declarations: no latency, no flow control.
package icache_pkg;

  localparam int ADDR_W     = 32;
  localparam int INDEX_W    = 6;
  localparam int OFFSET_W   = 2;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int LINE_W     = ADDR_W - OFFSET_W - 2;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 1 << INDEX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL
  } state_e;

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W+1:2];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[INDEX_W+OFFSET_W+1:OFFSET_W+2];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:ADDR_W-TAG_W];
  endfunction

  // Word-aligned line address with the in-line offset and byte bits stripped.
  function automatic logic [LINE_W-1:0] addr_line(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFFSET_W+2];
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Tag + valid storage: combinational lookup, synchronous tag/valid write, one-cycle flush-all.
// Lookup is 0-cycle, writes land on the next edge; no backpressure.
module icache_tag_array
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] lookup_index_i,
  input  logic [TAG_W-1:0]   lookup_tag_i,
  output logic               lookup_hit_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic               flush_all_i
);

  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  assign lookup_hit_o = valid_q[lookup_index_i] && (tag_q[lookup_index_i] == lookup_tag_i);

  // Tags are only trusted behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// I-cache controller: 0-cycle hits, miss = IDLE + REQ cycles + 4 beats + 1; stalls the CPU until refill, waits on mem_gnt.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic [ADDR_W-1:0]   cpu_addr,
  output logic                cpu_ready,
  output logic [31:0]         cpu_rdata,
  input  logic                flush,
  output logic                busy,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_rlast,
  output logic                refill_err,
  output logic [INDEX_W-1:0]  da_read_index,
  output logic [OFFSET_W-1:0] da_read_offset,
  input  logic [31:0]         da_read_data,
  output logic                da_write_enable,
  output logic [INDEX_W-1:0]  da_write_index,
  output logic [OFFSET_W-1:0] da_write_offset,
  output logic [31:0]         da_write_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  state_e              state_q;
  logic [LINE_W-1:0]   line_q;
  logic [OFFSET_W-1:0] cnt_q;
  logic                mem_req_q;
  logic                flush_pend_q;

  logic is_idle;
  logic flush_now;
  logic lookup_hit;
  logic hit;
  logic miss;
  logic fill_beat;
  logic beat_last;
  logic fill_ok;
  logic fill_err;

  assign is_idle   = (state_q == ST_IDLE);
  // A flush seen during a refill is replayed on the first IDLE cycle.
  assign flush_now = is_idle && (flush || flush_pend_q);
  assign hit       = is_idle && !flush_now && cpu_req && lookup_hit;
  assign miss      = is_idle && !flush_now && cpu_req && !lookup_hit;
  assign fill_beat = (state_q == ST_FILL) && mem_rvalid;
  assign beat_last = (cnt_q == OFFSET_W'(LINE_WORDS - 1));
  assign fill_ok   = fill_beat && beat_last && mem_rlast;
  assign fill_err  = fill_beat && (beat_last != mem_rlast);

  assign cpu_ready       = hit;
  assign cpu_rdata       = da_read_data;
  assign busy            = !is_idle;
  assign mem_req         = mem_req_q;
  assign mem_addr        = {line_q, {(OFFSET_W + 2){1'b0}}};
  assign refill_err      = fill_err;
  assign da_read_index   = addr_index(cpu_addr);
  assign da_read_offset  = addr_offset(cpu_addr);
  assign da_write_enable = fill_beat;
  assign da_write_index  = line_q[INDEX_W-1:0];
  assign da_write_offset = cnt_q;
  assign da_write_data   = mem_rdata;

  icache_tag_array u_tags (
    .clk            (clk),
    .rst_n          (rst_n),
    .lookup_index_i (addr_index(cpu_addr)),
    .lookup_tag_i   (addr_tag(cpu_addr)),
    .lookup_hit_o   (lookup_hit),
    .wr_en_i        (fill_ok),
    .wr_index_i     (line_q[INDEX_W-1:0]),
    .wr_tag_i       (line_q[LINE_W-1:INDEX_W]),
    .flush_all_i    (flush_now)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      if (!is_idle && flush) begin
        flush_pend_q <= 1'b1;
      end else if (flush_now) begin
        flush_pend_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (miss) begin
            line_q    <= addr_line(cpu_addr);
            mem_req_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (mem_rvalid) begin
            cnt_q <= cnt_q + OFFSET_W'(1);
            // Good last beat and any length mismatch both end the burst.
            if (beat_last || mem_rlast) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_q + 32'(hit);
      miss_cnt_q <= miss_cnt_q + 32'(miss);
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: directed fetches, a scripted memory port and a data-array model.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        flush = 1'b0;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rlast = 1'b0;
  logic        refill_err;
  logic [5:0]  da_read_index;
  logic [1:0]  da_read_offset;
  logic [31:0] da_read_data;
  logic        da_write_enable;
  logic [5:0]  da_write_index;
  logic [1:0]  da_write_offset;
  logic [31:0] da_write_data;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  logic [31:0] rdata_q[$];
  logic [31:0] addr_q[$];
  int          err_q[$];

  logic [31:0] da_mem [64][4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (da_write_enable) da_mem[da_write_index][da_write_offset] <= da_write_data;
  end
  assign da_read_data = da_mem[da_read_index][da_read_offset];

  icache_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_req         (cpu_req),
    .cpu_addr        (cpu_addr),
    .cpu_ready       (cpu_ready),
    .cpu_rdata       (cpu_rdata),
    .flush           (flush),
    .busy            (busy),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_gnt         (mem_gnt),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .mem_rlast       (mem_rlast),
    .refill_err      (refill_err),
    .da_read_index   (da_read_index),
    .da_read_offset  (da_read_offset),
    .da_read_data    (da_read_data),
    .da_write_enable (da_write_enable),
    .da_write_index  (da_write_index),
    .da_write_offset (da_write_offset),
    .da_write_data   (da_write_data)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  // Memory contents: line 0x150 returns 0x11,0x22,0x33,0x44; other lines an address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input int b);
    if (line == 32'h0000_0150) return 32'h11 * (b + 1);
    return {line[31:4], 4'(b)} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Scoreboard monitor: every DUT output event pops the oldest expectation.
  always @(negedge clk) begin
    if (cpu_ready) begin
      if (rdata_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: rdata %h with no pending fetch", cpu_rdata);
      end else begin
        check("cpu_rdata", cpu_rdata, rdata_q.pop_front());
      end
    end
    if (mem_req && mem_gnt) begin
      if (addr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_grant: mem_addr %h with no expected refill", mem_addr);
      end else begin
        check("mem_addr", mem_addr, addr_q.pop_front());
      end
    end
    if (refill_err) begin
      if (err_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_refill_err: at beat %0d", da_write_offset);
      end else begin
        check("refill_err_beat", 32'(da_write_offset), 32'(err_q.pop_front()));
      end
    end
  end

  task automatic start_req(input logic [31:0] a);
    cpu_req  = 1'b1;
    cpu_addr = a;
  endtask

  // Plays the memory side of one burst; rlast_at marks the beat carrying rlast.
  task automatic serve(input logic [31:0] line, input int rlast_at, input int nbeats, input int flush_beat);
    int waited = 0;
    while (!mem_req && waited < 30) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!mem_req) begin
      timed_out("mem_req_wait");
      return;
    end
    addr_q.push_back(line);
    exp_misses++;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if ((b == rlast_at) != (b == 3)) err_q.push_back(b);
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(line, b);
      mem_rlast  = (b == rlast_at);
      flush      = (b == flush_beat);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic wait_ready(output int rc);
    int waited = 0;
    rdata_q.push_back(mem_word({cpu_addr[31:4], 4'h0}, int'(cpu_addr[3:2])));
    exp_hits++;
    rc = -1;
    while (waited < 30) begin
      @(negedge clk);
      if (cpu_ready) begin
        rc = cyc;
        break;
      end
      waited++;
    end
    if (rc < 0) timed_out("cpu_ready_wait");
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r1, r2, r3;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_refill_err", 32'(refill_err), 32'd0);
    check("rst_da_we", 32'(da_write_enable), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss at 0x154
    start_req(32'h0000_0154);
    t0 = cyc;
    @(negedge clk);
    check("da_read_index", 32'(da_read_index), 32'd21);
    check("da_read_offset", 32'(da_read_offset), 32'd1);
    check("miss_no_ready", 32'(cpu_ready), 32'd0);
    serve(32'h0000_0150, 3, 4, -1);
    wait_ready(r1);
    check("miss_latency_cycles", 32'(r1 - t0 + 1), 32'd7);
    for (int b = 0; b < 4; b++) check("da_line21", da_mem[21][b], 32'h11 * (b + 1));

    // Back-to-back hits
    start_req(32'h0000_0150); wait_ready(r1);
    start_req(32'h0000_0158); wait_ready(r2);
    start_req(32'h0000_015C); wait_ready(r3);
    check("b2b_hit_span", 32'(r3 - r1), 32'd2);
    check("hit_no_mem_req", 32'(mem_req), 32'd0);
    check("hit_not_busy", 32'(busy), 32'd0);

    // Conflict on index 21
    start_req(32'h0000_0550);
    serve(32'h0000_0550, 3, 4, -1);
    wait_ready(r1);
    start_req(32'h0000_0150);
    serve(32'h0000_0150, 3, 4, -1);
    wait_ready(r1);

    // Flush in IDLE beats a hitting request
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_no_ready", 32'(cpu_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    serve(32'h0000_0150, 3, 4, -1);
    wait_ready(r1);

    // Flush during FILL: the fresh line is invalidated, so the request refills again
    start_req(32'h0000_0550);
    serve(32'h0000_0550, 3, 4, 1);
    serve(32'h0000_0550, 3, 4, -1);
    wait_ready(r1);

    // Burst error: rlast on beat 2, then automatic retry
    start_req(32'h0000_0150);
    serve(32'h0000_0150, 2, 3, -1);
    serve(32'h0000_0150, 3, 4, -1);
    wait_ready(r1);

    // Reset in the middle of FILL
    start_req(32'h0000_0550);
    serve(32'h0000_0550, 3, 2, -1);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("midfill_rst_mem_req", 32'(mem_req), 32'd0);
    check("midfill_rst_busy", 32'(busy), 32'd0);
    exp_hits = 0;
    exp_misses = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_req(32'h0000_0150);
    serve(32'h0000_0150, 3, 4, -1);
    wait_ready(r1);
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

`ifdef ICACHE_PERF_CNT_EN
    check("hit_count", hit_count, 32'(exp_hits));
    check("miss_count", miss_count, 32'(exp_misses));
    check("hit_count_hand", hit_count, 32'd1);
    check("miss_count_hand", miss_count, 32'd1);
`endif

    check("rdata_q_drained", 32'(rdata_q.size()), 32'd0);
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    check("err_q_drained", 32'(err_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
